ccd_frame_capture: RTL and testbench

//   Front-end stage directly upstream of the Bayer/grey/convolution image processor.

---
 rtl/ccd_frame_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture
//   Front end of the image pipeline. Qualifies raw sensor pixels with frame/line valid, gates
//   capture with start/stop commands, and presents registered pixel data, data-valid and X/Y
//   coordinates for the downstream processor. Keeps a count of frames whose capture started.
//
//   Latency: a pixel presented on iDATA at cycle n appears on oDATA with oDVAL=1 at cycle n+2
//   (stage 1 registers the sensor inputs, stage 2 produces the outputs).
//
// Configuration macro:
//   TEST_PATTERN_EN - adds input iPATTERN; when high, oDATA carries (X + Y) instead of iDATA.
//
// Ports:
//   iCLK         pixel clock, rising edge
//   iRST         asynchronous active-high reset
//   iDATA        raw sensor pixel
//   iFVAL/iLVAL  sensor frame / line valid
//   iSTART       one-cycle pulse, arm capture
//   iEND         one-cycle pulse, stop after the current frame
//   iPATTERN     (TEST_PATTERN_EN only) select coordinate test pattern
//   oDATA        captured pixel (holds when oDVAL=0)
//   oDVAL        oDATA/oX_Cont/oY_Cont describe a valid pixel
//   oX_Cont      column of the pixel on oDATA
//   oY_Cont      row of the pixel on oDATA
//   oFrame_Cont  number of frames whose capture has started (wraps)
//   oBusy        capture engine is armed, capturing or draining
module ccd_frame_capture #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned LINE_WIDTH = 1280,
  parameter int unsigned FCNT_W     = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
`ifdef TEST_PATTERN_EN
  input  logic              iPATTERN,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont,
  output logic [FCNT_W-1:0] oFrame_Cont,
  output logic              oBusy
);

  localparam logic [CNT_W-1:0] XLast = CNT_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;

  state_e state_q, state_d;

  // Stage 1: registered sensor inputs, plus a delayed frame valid for edge detection.
  logic [DATA_W-1:0] data_s1_q;
  logic              fval_s1_q;
  logic              lval_s1_q;
  logic              fval_prev_q;
`ifdef TEST_PATTERN_EN
  logic              pattern_s1_q;
`endif

  // Stage 2: output registers and the coordinate the next valid pixel will receive.
  logic [DATA_W-1:0] data_q, data_d;
  logic              dval_q, dval_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]  x_nxt_q, x_nxt_d;
  logic [CNT_W-1:0]  y_nxt_q, y_nxt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              fval_rise;
  logic              fval_fall;
  logic              cap_active;
  logic              busy;
  logic              frame_start;
  logic              pix_valid;
  logic [CNT_W-1:0]  x_pix;
  logic [CNT_W-1:0]  y_pix;
  logic [DATA_W-1:0] pix_src;

  assign fval_rise = fval_s1_q & ~fval_prev_q;
  assign fval_fall = ~fval_s1_q & fval_prev_q;

  // ---------------------------------------------------------------------------
  // Stage 1 input registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_s1_q    <= '0;
      fval_s1_q    <= 1'b0;
      lval_s1_q    <= 1'b0;
      fval_prev_q  <= 1'b0;
`ifdef TEST_PATTERN_EN
      pattern_s1_q <= 1'b0;
`endif
    end else begin
      data_s1_q    <= iDATA;
      fval_s1_q    <= iFVAL;
      lval_s1_q    <= iLVAL;
      fval_prev_q  <= fval_s1_q;
`ifdef TEST_PATTERN_EN
      pattern_s1_q <= iPATTERN;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A simultaneous start and end cancels out.
        if (iSTART && !iEND) state_d = StArmed;
      end
      StArmed: begin
        // Only a fresh frame edge starts capture; a frame already in flight is skipped.
        if (iEND) begin
          state_d = StIdle;
        end else if (fval_rise) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (iEND) state_d = StDrain;
      end
      StDrain: begin
        if (fval_fall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    cap_active = 1'b0;
    unique case (state_q)
      // The frame edge that moves ARMED to CAPTURE also carries the frame's first cycle.
      StArmed:            cap_active = fval_rise & ~iEND;
      StCapture, StDrain: cap_active = 1'b1;
      default:            cap_active = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: qualification, coordinates, frame count, output data
  // ---------------------------------------------------------------------------
  assign frame_start = cap_active & fval_rise;
  assign pix_valid   = cap_active & fval_s1_q & lval_s1_q;

  // Coordinate of the pixel in stage 1; a frame start forces it to the origin.
  assign x_pix = frame_start ? '0 : x_nxt_q;
  assign y_pix = frame_start ? '0 : y_nxt_q;

`ifdef TEST_PATTERN_EN
  logic [CNT_W:0] pat_sum;
  assign pat_sum = {1'b0, x_pix} + {1'b0, y_pix};
  assign pix_src = pattern_s1_q ? DATA_W'(pat_sum) : data_s1_q;
`else
  assign pix_src = data_s1_q;
`endif

  always_comb begin
    data_d  = data_q;
    dval_d  = pix_valid;
    x_d     = x_q;
    y_d     = y_q;
    x_nxt_d = x_nxt_q;
    y_nxt_d = y_nxt_q;
    fcnt_d  = fcnt_q;

    if (frame_start) begin
      fcnt_d  = fcnt_q + FCNT_W'(1);
      x_nxt_d = '0;
      y_nxt_d = '0;
    end

    if (pix_valid) begin
      data_d = pix_src;
      x_d    = x_pix;
      y_d    = y_pix;
      // Coordinates follow the pixel count; short or long lines are not realigned.
      if (x_pix == XLast) begin
        x_nxt_d = '0;
        y_nxt_d = y_pix + CNT_W'(1);
      end else begin
        x_nxt_d = x_pix + CNT_W'(1);
        y_nxt_d = y_pix;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_q  <= '0;
      dval_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      x_nxt_q <= '0;
      y_nxt_q <= '0;
      fcnt_q  <= '0;
    end else begin
      data_q  <= data_d;
      dval_q  <= dval_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_nxt_q <= x_nxt_d;
      y_nxt_q <= y_nxt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = x_q;
  assign oY_Cont     = y_q;
  assign oFrame_Cont = fcnt_q;
  assign oBusy       = busy;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed bench for ccd_frame_capture. Stimulus tasks drive frames and queue the pixels that
// must come out; a monitor on the falling edge compares every output pixel (data, X, Y, exact
// two-cycle latency) and flags any oDVAL when nothing is expected.
`timescale 1ns/1ps
module tb_ccd_frame_capture;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned LINE_WIDTH = 1280;
  localparam int unsigned FCNT_W     = 32;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic [DATA_W-1:0] iDATA;
  logic              iFVAL;
  logic              iLVAL;
  logic              iSTART;
  logic              iEND;
`ifdef TEST_PATTERN_EN
  logic              iPATTERN = 1'b0;
`endif
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX_Cont;
  logic [CNT_W-1:0]  oY_Cont;
  logic [FCNT_W-1:0] oFrame_Cont;
  logic              oBusy;

  ccd_frame_capture #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .LINE_WIDTH (LINE_WIDTH),
    .FCNT_W     (FCNT_W)
  ) u_dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
`ifdef TEST_PATTERN_EN
    .iPATTERN    (iPATTERN),
`endif
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oBusy       (oBusy)
  );

  always #5 iCLK = ~iCLK;

  int unsigned cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    int unsigned       cyc;
  } pix_t;

  pix_t exp_q[$];
  bit   mon_en = 1'b0;

  always @(negedge iCLK) begin : mon
    pix_t e;
    if (mon_en && !iRST) begin
      if (exp_q.size() == 0) begin
        chk("spurious_dval", 64'(oDVAL), 64'd0);
      end else begin
        e = exp_q[0];
        chk("dval_latency", 64'(oDVAL), 64'(cyc == e.cyc + 2));
        if (oDVAL || cyc >= e.cyc + 2) void'(exp_q.pop_front());
        if (oDVAL) begin
          chk("pix_data", 64'(oDATA), 64'(e.data));
          chk("pix_x", 64'(oX_Cont), 64'(e.x));
          chk("pix_y", 64'(oY_Cont), 64'(e.y));
        end
      end
    end
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST   = 1'b1;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = '0;
    repeat (2) step();
    exp_q.delete();
    iRST = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    step();
  endtask

  // One frame: 2-cycle front porch, lines separated by 3 idle cycles, 4-cycle frame gap.
  // cap: pixels are expected on the output. start_at/end_at: pixel index carrying the pulse.
  task automatic send_frame(input int lines, input int ppl, input bit cap,
                            input int start_at, input int end_at, input bit pat);
    int   idx;
    int   x;
    int   y;
    pix_t p;
    idx = 0;
    x   = 0;
    y   = 0;
`ifdef TEST_PATTERN_EN
    iPATTERN = pat;
`endif
    iFVAL = 1'b1;
    iLVAL = 1'b0;
    repeat (2) step();
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < ppl; i++) begin
        iLVAL  = 1'b1;
        iDATA  = DATA_W'(idx);
        iSTART = (idx == start_at);
        iEND   = (idx == end_at);
        if (cap) begin
          p.data = pat ? DATA_W'(x + y) : DATA_W'(idx);
          p.x    = CNT_W'(x);
          p.y    = CNT_W'(y);
          p.cyc  = cyc;
          exp_q.push_back(p);
          if (x == int'(LINE_WIDTH) - 1) begin
            x = 0;
            y++;
          end else begin
            x++;
          end
        end
        idx++;
        step();
      end
      iLVAL  = 1'b0;
      iSTART = 1'b0;
      iEND   = 1'b0;
      repeat (3) step();
    end
    iFVAL = 1'b0;
    repeat (4) step();
`ifdef TEST_PATTERN_EN
    iPATTERN = 1'b0;
`endif
  endtask

  initial begin
    iRST   = 1'b1;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = '0;
    repeat (2) step();
    chk("rst_dval", 64'(oDVAL), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_fcnt", 64'(oFrame_Cont), 64'd0);
    iRST = 1'b0;
    step();

    // T1: reset mid-frame aborts, then no output without a new start and frame edge.
    mon_en = 1'b0;
    pulse_start();
    iFVAL = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      iLVAL = 1'b1;
      iDATA = DATA_W'(i + 100);
      step();
    end
    chk("t1_pre_dval", 64'(oDVAL), 64'd1);
    chk("t1_pre_busy", 64'(oBusy), 64'd1);
    chk("t1_pre_fcnt", 64'(oFrame_Cont), 64'd1);
    #2;
    iRST = 1'b1;
    #1;
    chk("t1_rst_data", 64'(oDATA), 64'd0);
    chk("t1_rst_dval", 64'(oDVAL), 64'd0);
    chk("t1_rst_x", 64'(oX_Cont), 64'd0);
    chk("t1_rst_y", 64'(oY_Cont), 64'd0);
    chk("t1_rst_fcnt", 64'(oFrame_Cont), 64'd0);
    chk("t1_rst_busy", 64'(oBusy), 64'd0);
    step();
    iRST   = 1'b0;
    mon_en = 1'b1;
    repeat (20) step();
    iLVAL = 1'b0;
    iFVAL = 1'b0;
    repeat (4) step();
    send_frame(1, 30, 1'b0, -1, -1, 1'b0);
    chk("t1_fcnt", 64'(oFrame_Cont), 64'd0);
    chk("t1_busy", 64'(oBusy), 64'd0);

    // T2: two full lines, pixel index as data.
    do_reset();
    pulse_start();
    chk("t2_armed_busy", 64'(oBusy), 64'd1);
    send_frame(2, 1280, 1'b1, -1, -1, 1'b0);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);
    chk("t2_last_x", 64'(oX_Cont), 64'd1279);
    chk("t2_last_y", 64'(oY_Cont), 64'd1);
    chk("t2_last_data", 64'(oDATA), 64'd2559);
    chk("t2_fcnt", 64'(oFrame_Cont), 64'd1);
    chk("t2_busy", 64'(oBusy), 64'd1);

    // T5a: line valid without frame valid is ignored while capturing.
    iFVAL = 1'b0;
    iLVAL = 1'b1;
    repeat (50) step();
    iLVAL = 1'b0;
    repeat (2) step();
    chk("t5_hold_x", 64'(oX_Cont), 64'd1279);
    chk("t5_hold_y", 64'(oY_Cont), 64'd1);
    chk("t5_hold_fcnt", 64'(oFrame_Cont), 64'd1);

    // T5b: start and end together in IDLE.
    do_reset();
    iSTART = 1'b1;
    iEND   = 1'b1;
    step();
    iSTART = 1'b0;
    iEND   = 1'b0;
    chk("t5_se_busy0", 64'(oBusy), 64'd0);
    step();
    chk("t5_se_busy1", 64'(oBusy), 64'd0);

    // T3: arming mid-frame skips that frame; the next one is captured.
    do_reset();
    send_frame(2, 40, 1'b0, 15, -1, 1'b0);
    chk("t3_skip_fcnt", 64'(oFrame_Cont), 64'd0);
    chk("t3_armed_busy", 64'(oBusy), 64'd1);
    send_frame(2, 40, 1'b1, -1, -1, 1'b0);
    chk("t3_fcnt", 64'(oFrame_Cont), 64'd1);
    chk("t3_last_x", 64'(oX_Cont), 64'd79);
    chk("t3_last_y", 64'(oY_Cont), 64'd0);

    // T4: stop during frame 3; frame 3 completes, frame 4 is not captured.
    do_reset();
    pulse_start();
    send_frame(1, 150, 1'b1, -1, -1, 1'b0);
    send_frame(1, 150, 1'b1, -1, -1, 1'b0);
    chk("t4_fcnt2", 64'(oFrame_Cont), 64'd2);
    send_frame(1, 150, 1'b1, -1, 100, 1'b0);
    chk("t4_idle_busy", 64'(oBusy), 64'd0);
    chk("t4_fcnt3", 64'(oFrame_Cont), 64'd3);
    send_frame(1, 150, 1'b0, -1, -1, 1'b0);
    chk("t4_f4_fcnt", 64'(oFrame_Cont), 64'd3);
    chk("t4_f4_busy", 64'(oBusy), 64'd0);
    chk("t4_hold_x", 64'(oX_Cont), 64'd149);

`ifdef TEST_PATTERN_EN
    // T6: coordinate pattern over 1300-pixel lines (X wraps at 1279 regardless of line valid).
    do_reset();
    pulse_start();
    send_frame(4, 1300, 1'b1, -1, -1, 1'b1);
    chk("t6_last_x", 64'(oX_Cont), 64'd79);
    chk("t6_last_y", 64'(oY_Cont), 64'd4);
    chk("t6_last_data", 64'(oDATA), 64'd83);
`endif

    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
